debug_display_ctrl: RTL and testbench

Parametrised successor to the board-level debug display driver. It selects a pipeline-stage PC/opcode or a register value using the switches. A sequential FSM converts that value into per-digit 7-segment codes in decimal or hexadecimal, with leading-zero blanking and overflow indication. The value is re-sampled periodically so the display tracks live changes. It sits between the CPU debug taps and the board HEX/LEDR pins.

---
 rtl/debug_display_ctrl_if.sv | 29 ++
 rtl/debug_display_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_debug_display_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/debug_display_ctrl_if.sv
// rtl/debug_display_ctrl_if.sv - CPU debug taps in, board display pins out
interface debug_display_ctrl_if #(
  parameter int NUM_STAGES = 7,
  parameter int PC_W       = 7,
  parameter int OP_W       = 7,
  parameter int REG_W      = 32,
  parameter int NUM_DIGITS = 6
);
  logic [NUM_STAGES*PC_W-1:0] pc_taps;
  logic [NUM_STAGES*OP_W-1:0] op_taps;
  logic [REG_W-1:0]           selected_register;
  logic [REG_W-1:0]           status_register;
  logic [9:0]                 SW;
  logic                       radix_hex;
  logic [NUM_DIGITS*7-1:0]    hex_out;
  logic [9:0]                 LEDR;
  logic                       busy;
  logic                       overflow;

  modport master (
    output pc_taps, op_taps, selected_register, status_register, SW, radix_hex,
    input  hex_out, LEDR, busy, overflow
  );

  modport slave (
    input  pc_taps, op_taps, selected_register, status_register, SW, radix_hex,
    output hex_out, LEDR, busy, overflow
  );
endinterface

// File: rtl/debug_display_ctrl.sv
// rtl/debug_display_ctrl.sv - selects a debug value and converts it to 7-segment digits
module debug_display_ctrl #(
  parameter int NUM_STAGES     = 7,
  parameter int PC_W           = 7,
  parameter int OP_W           = 7,
  parameter int REG_W          = 32,
  parameter int VAL_W          = 20,
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  debug_display_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_COMMIT} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VAL_W-1:0]        work_q, work_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              shadow_q [NUM_DIGITS];
  logic [6:0]              shadow_d [NUM_DIGITS];
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
  logic                    ovf_q, ovf_d;
  logic [9:0]              sw_q, sw_d;
  logic                    radix_q, radix_d;
  logic                    pend_q, pend_d;

  logic [OP_W-1:0]  live_op;
  logic [PC_W-1:0]  cap_pc;
  logic [VAL_W-1:0] cap_value;
  logic [3:0]       digit;
  logic [VAL_W-1:0] next_work;
  logic             change_now;
  logic             lead;
  logic             unused_bits;

  // Register bits outside the displayed window are intentionally ignored
  assign unused_bits = ^{bus.selected_register, bus.status_register};

  // Stage tap muxes: live switches drive the LEDs, registered switches feed the converter
  always_comb begin
    live_op = '0;
    cap_pc  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (bus.SW[2:0] == 3'(i)) live_op = bus.op_taps[i*OP_W +: OP_W];
      if (sw_q[2:0] == 3'(i))   cap_pc  = bus.pc_taps[i*PC_W +: PC_W];
    end
    if (sw_q[8]) begin
      if (sw_q[7:3] == 5'b10000) cap_value = VAL_W'(bus.status_register[REG_W-1 -: 12]);
      else                       cap_value = bus.selected_register[VAL_W-1:0];
    end else begin
      cap_value = VAL_W'(cap_pc);
    end
  end

  // One digit step in the selected radix
  always_comb begin
    if (radix_q) begin
      digit     = work_q[3:0];
      next_work = work_q >> 4;
    end else begin
      digit     = 4'(work_q % VAL_W'(10));
      next_work = work_q / VAL_W'(10);
    end
  end

  assign change_now = (bus.SW != sw_q) || (bus.radix_hex != radix_q);

  // Conversion FSM: next state, datapath updates and committed display image
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    sw_d     = bus.SW;
    radix_d  = bus.radix_hex;
    lead     = 1'b1;
    // A change seen during COMMIT must survive into IDLE; elsewhere it is acted on now
    pend_d   = change_now || (pend_q && (state_q == S_COMMIT));
    case (state_q)
      S_IDLE: begin
        if (pend_q || (cnt_q == '0)) state_d = S_LOAD;
        else                         cnt_d   = cnt_q - 1'b1;
      end
      S_LOAD: begin
        if (!pend_q) begin
          work_d   = cap_value;
          idx_d    = '0;
          shadow_d = '{default: SEG_BLANK};
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        if (pend_q) begin
          state_d = S_LOAD;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) shadow_d[i] = seg7(digit);
          end
          work_d = next_work;
          if (idx_q == LAST_IDX) state_d = S_COMMIT;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      default: begin
        ovf_d = (work_q != '0);
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
          lead = lead && (shadow_q[i] == SEG_ZERO);
          if (work_q != '0)          hex_d[i*7 +: 7] = SEG_DASH;
          else if (lead && (i != 0)) hex_d[i*7 +: 7] = SEG_BLANK;
          else                       hex_d[i*7 +: 7] = shadow_q[i];
        end
        cnt_d   = RELOAD;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves the counter at 0 to convert immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '{default: SEG_BLANK};
      hex_q    <= '1;
      ovf_q    <= 1'b0;
      sw_q     <= '0;
      radix_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      sw_q     <= sw_d;
      radix_q  <= radix_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.hex_out  = bus.SW[9] ? hex_q : '1;
  assign bus.LEDR     = (!bus.SW[9] || bus.SW[8]) ? '1 : ~(10'(live_op));
  assign bus.busy     = (state_q == S_LOAD) || (state_q == S_CONV);
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_debug_display_ctrl.sv
// tb/tb_debug_display_ctrl.sv - directed vector bench for debug_display_ctrl
module tb_debug_display_ctrl;
  localparam int ND = 6;
  localparam int RC = 1024;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  debug_display_ctrl_if #(.NUM_STAGES(7), .PC_W(7), .OP_W(7), .REG_W(32), .NUM_DIGITS(ND)) dif ();

  debug_display_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]      sw;
    logic            radix;
    logic [31:0]     selr;
    logic [31:0]     stat;
    logic [ND*7-1:0] hex;
    logic            ovf;
    logic [9:0]      ledr;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [ND*7-1:0] d6(input logic [6:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [9:0] sw, input logic radix, input logic [31:0] selr,
                       input logic [31:0] stat);
    dif.SW                = sw;
    dif.radix_hex         = radix;
    dif.selected_register = selr;
    dif.status_register   = stat;
  endtask

  logic [ND*7-1:0] all_ones;
  logic [ND*7-1:0] old_hex, new_hex;
  int              n;
  bit              done;

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    all_ones = '1;

    vecs[0]  = '{10'h203, 1'b0, 32'h0, 32'h0, d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h30), 1'b0, 10'h3D5};
    vecs[1]  = '{10'h202, 1'b0, 32'h0, 32'h0, d6(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40), 1'b0, 10'h380};
    vecs[2]  = '{10'h202, 1'b1, 32'h0, 32'h0, d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h19), 1'b0, 10'h380};
    vecs[3]  = '{10'h200, 1'b1, 32'h0, 32'h0, d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0, 10'h3FC};
    vecs[4]  = '{10'h207, 1'b1, 32'h0, 32'h0, d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0, 10'h3FF};
    vecs[5]  = '{10'h204, 1'b0, 32'h0, 32'h0, d6(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h78), 1'b0, 10'h3FE};
    vecs[6]  = '{10'h300, 1'b0, 32'h000F_FFFF, 32'h0, d6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1, 10'h3FF};
    vecs[7]  = '{10'h300, 1'b1, 32'h000F_FFFF, 32'h0, d6(7'h7F, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E), 1'b0, 10'h3FF};
    vecs[8]  = '{10'h380, 1'b0, 32'h000F_FFFF, 32'h6000_0000, d6(7'h7F, 7'h7F, 7'h79, 7'h12, 7'h30, 7'h02), 1'b0, 10'h3FF};
    vecs[9]  = '{10'h380, 1'b1, 32'h000F_FFFF, 32'h6000_0000, d6(7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h40, 7'h40), 1'b0, 10'h3FF};
    vecs[10] = '{10'h308, 1'b0, 32'hABCF_423F, 32'h0, d6(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 1'b0, 10'h3FF};
    vecs[11] = '{10'h008, 1'b0, 32'h0, 32'h0, all_ones, 1'b0, 10'h3FF};

    dif.pc_taps = {7'd64, 7'd5, 7'd127, 7'd93, 7'd100, 7'd7, 7'd0};
    dif.op_taps = {7'h66, 7'h55, 7'h01, 7'h2A, 7'h7F, 7'h15, 7'h03};
    apply(10'h203, 1'b0, 32'h0, 32'h0);

    // Reset state
    rst = 1'b1;
    cyc(3);
    chk("reset_hex", dif.hex_out, all_ones);
    chk("reset_busy", dif.busy, 1'b0);
    chk("reset_ovf", dif.overflow, 1'b0);
    rst = 1'b0;
    cyc(30);
    chk("post_reset_hex", dif.hex_out, vecs[0].hex);
    chk("post_reset_ledr", dif.LEDR, 10'h3D5);

    // Exact latency: new digits appear on the (ND+3)th edge after the sampling edge
    apply(10'h200, 1'b0, 32'h0, 32'h0);
    cyc(ND + 3);
    chk("latency_before", dif.hex_out, vecs[0].hex);
    cyc(1);
    chk("latency_after", dif.hex_out, d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].sw, vecs[i].radix, vecs[i].selr, vecs[i].stat);
      cyc(14);
      chk($sformatf("vec%0d_hex", i), dif.hex_out, vecs[i].hex);
      chk($sformatf("vec%0d_ovf", i), dif.overflow, vecs[i].ovf);
      chk($sformatf("vec%0d_ledr", i), dif.LEDR, vecs[i].ledr);
      chk($sformatf("vec%0d_busy", i), dif.busy, 1'b0);
    end

    // Abort mid-conversion: only old or final digits may ever be visible
    old_hex = d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    new_hex = d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    apply(10'h203, 1'b0, 32'h0, 32'h0);
    cyc(5);
    chk("abort_busy", dif.busy, 1'b1);
    chk("abort_hold_pre", dif.hex_out, old_hex);
    dif.SW = 10'h201;
    n = 0;
    done = 1'b0;
    while (!done && n < 30) begin
      cyc(1);
      n++;
      chk("abort_no_mixed", (dif.hex_out == old_hex) || (dif.hex_out == new_hex), 1'b1);
      if (dif.hex_out != old_hex) done = 1'b1;
    end
    chk("abort_done", done, 1'b1);
    chk("abort_cycles", n, 10);
    chk("abort_final", dif.hex_out, new_hex);
    chk("abort_ledr", dif.LEDR, 10'h3EA);

    // Periodic refresh picks up tap changes without switch activity
    apply(10'h205, 1'b0, 32'h0, 32'h0);
    cyc(14);
    chk("refresh_initial", dif.hex_out, d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12));
    chk("refresh_ledr", dif.LEDR, 10'h3AA);
    dif.pc_taps[5*7 +: 7] = 7'd42;
    n = 0;
    done = 1'b0;
    while (!done && n < RC + ND + 5) begin
      cyc(1);
      n++;
      if (dif.hex_out == d6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24)) done = 1'b1;
    end
    chk("refresh_update", done, 1'b1);

    // Asynchronous reset in the middle of a conversion
    apply(10'h300, 1'b0, 32'h000F_FFFF, 32'h0);
    cyc(14);
    chk("rst_pre_ovf", dif.overflow, 1'b1);
    chk("rst_pre_hex", dif.hex_out, d6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F));
    dif.radix_hex = 1'b1;
    cyc(5);
    chk("rst_mid_busy_pre", dif.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_hex", dif.hex_out, all_ones);
    chk("rst_async_busy", dif.busy, 1'b0);
    chk("rst_async_ovf", dif.overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(20);
    chk("rst_recover_hex", dif.hex_out, d6(7'h7F, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E));
    chk("rst_recover_ovf", dif.overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
